lsu_align: RTL and testbench
============================

Name: lsu_align

Overview:
- Load/store alignment unit between the EX/MEM pipeline register and the 64-bit data memory (DM).
- Converts byte-addressed requests of size byte/half/word/double into the DM's double-word-indexed accesses.
- Performs sub-word stores as a two-cycle read-modify-write (RMW).
- Sign- or zero-extends load data and returns a registered response to the MEM/WB stage.

Parameters:
- DEPTH, 64, number of 64-bit DM entries; valid double-word indices are 0..DEPTH-1.
- IDX_W, 6, width of the DM index actually used; equals log2(DEPTH).

Ports:
- clk  input  1  clock.
- rst  input  1  reset; one clock; reset is asynchronous and active-high.
- req_valid  input  1  request present.
- req_ready  output  1  unit can accept a request this cycle.
- req_we  input  1  1 = store, 0 = load.
- req_size  input  2  0 = byte, 1 = half, 2 = word, 3 = double.
- req_unsigned  input  1  zero-extend load when 1, sign-extend when 0.
- req_addr  input  64  byte address.
- req_wdata  input  64  store data; the value is in the low bits.
- resp_valid  output  1  one-cycle pulse: request completed.
- resp_rdata  output  64  extended load data; 0 for stores and errors.
- resp_err  output  1  request was misaligned or out of range.
- dm_addr  output  64  DM index, zero-extended to 64 bits.
- dm_wdata  output  64  DM write data.
- dm_memwrite  output  1  DM write enable.
- dm_memread  output  1  DM read enable.
- dm_rdata  input  64  DM combinational read data.

Behaviour:
- Reset values: state = IDLE; resp_valid, resp_err, resp_rdata = 0; dm_memwrite = 0. All outputs are low while rst is high.
- Address decode:
  - off = req_addr[2:0]; idx = req_addr[63:3].
  - Misaligned when off is not a multiple of (1 << req_size).
  - Out of range when idx >= DEPTH.
  - Byte lanes are little-endian: byte k lives at bits [8k+7:8k].
- State machine, IDLE:
  - req_ready = 1.
  - dm_addr = idx; dm_memread = req_valid & aligned & in-range.
- Transitions from IDLE on req_valid:
  - Error (misaligned or out of range): no DM access. Next cycle resp_valid = 1, resp_err = 1, resp_rdata = 0. Stay in IDLE.
  - Load: dm_rdata is lane-selected at off and extended per req_size and req_unsigned, then registered. Next cycle resp_valid = 1 with that data. Latency 1.
  - Store, size 3: dm_memwrite = 1 and dm_wdata = req_wdata in the same cycle. Next cycle resp_valid = 1. Latency 1.
  - Store, size 0/1/2: the merged word is registered. merged = dm_rdata with the addressed lanes replaced by req_wdata's low bytes. Other lanes are unchanged. Also register idx. Go to RMW_WR.
- State machine, RMW_WR:
  - req_ready = 0; dm_memread = 0.
  - dm_memwrite = 1; dm_addr = registered idx; dm_wdata = registered merged word.
  - Next cycle: resp_valid = 1, return to IDLE. Total store latency 2.
- Back-to-back traffic:
  - A new request may be accepted in the same cycle a previous response pulses, whenever state is IDLE.
  - resp_valid is never high for two cycles for one request.
- A request presented during RMW_WR is not accepted. The upstream holds it until req_ready = 1.
- Reset mid-RMW: the unit returns to IDLE immediately, no write is issued, and no response is produced.
- Load width rules:
  - Byte: bit 7 extends to 64 bits.
  - Half: bit 15 extends.
  - Word: bit 31 extends.
  - Double: passed unchanged; req_unsigned is ignored.
- Store width rule: only the low 8·2^size bits of req_wdata are used.
- DM integration: the DM's reset is active-low, so the top level drives it with the inversion of rst.

Test Plan:
1. Preload DM[2] = 0x8877665544332211. Byte load at addr 0x17 (idx 2, off 7), signed, then unsigned -> resp_rdata = 0xFFFFFFFFFFFFFF88, then 0x0000000000000088. Each response arrives 1 cycle after acceptance.
2. Half store of 0xBEEF at addr 0x12 onto DM[2] = 0x8877665544332211 -> req_ready low for 1 cycle, dm_memwrite high in the RMW_WR cycle, DM[2] = 0x88776655BEEF2211. resp_valid arrives 2 cycles after acceptance.
3. Word load at addr 0x16 (misaligned) and double load at addr 0x200 (idx 64, out of range) -> resp_err = 1, resp_rdata = 0, dm_memwrite and dm_memread stay 0.
4. Double store 0x0123456789ABCDEF at addr 0x08, then an immediate load of the same address on the next IDLE cycle -> DM[1] updated in 1 cycle; load returns 0x0123456789ABCDEF.
5. Byte store issued, then rst asserted during RMW_WR -> DM contents unchanged, no resp_valid, state = IDLE, req_ready = 1 after reset release.
6. Word store held valid back-to-back with a load behind it -> the load is accepted only after the RMW completes, and exactly one resp_valid is produced per request, in order.

Source files
------------

// File: rtl/lsu_align.sv
// lsu_align: byte-addressed load/store alignment onto a 64-bit double-word data memory.
// Loads, double stores and errors respond 1 cycle after acceptance; sub-word stores take 2 (RMW) with req_ready low during the write.
module lsu_align #(
  parameter int DEPTH = 64,
  parameter int IDX_W = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  output logic [63:0] resp_rdata,
  output logic        resp_err,
  output logic [63:0] dm_addr,
  output logic [63:0] dm_wdata,
  output logic        dm_memwrite,
  output logic        dm_memread,
  input  logic [63:0] dm_rdata
);

  typedef enum logic {IDLE, RMW_WR} state_t;

  state_t             state_q, state_d;
  logic               resp_valid_q, resp_valid_d;
  logic               resp_err_q, resp_err_d;
  logic [63:0]        resp_rdata_q, resp_rdata_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [63:0]        merged_q, merged_d;

  logic [2:0]  off;
  logic [60:0] idx;
  logic [2:0]  off_mask;
  logic        aligned, in_range, req_ok;
  logic [7:0]  lane_base, lane_mask;
  logic [63:0] bit_mask, rd_shift, wr_shift, merged, load_ext;

  always_comb begin
    off      = req_addr[2:0];
    idx      = req_addr[63:3];
    off_mask = 3'((4'd1 << req_size) - 4'd1);
    aligned  = (off & off_mask) == 3'd0;
    in_range = idx < 61'(DEPTH);
    req_ok   = aligned && in_range;

    case (req_size)
      2'd0:    lane_base = 8'h01;
      2'd1:    lane_base = 8'h03;
      2'd2:    lane_base = 8'h0F;
      default: lane_base = 8'hFF;
    endcase
    lane_mask = lane_base << off;
    bit_mask  = '0;
    for (int k = 0; k < 8; k++) begin
      bit_mask[8*k +: 8] = {8{lane_mask[k]}};
    end

    // Lane select for loads shifts the addressed byte down to bit 0; stores shift data up.
    rd_shift = dm_rdata >> {off, 3'b000};
    wr_shift = req_wdata << {off, 3'b000};
    merged   = (dm_rdata & ~bit_mask) | (wr_shift & bit_mask);

    case (req_size)
      2'd0:    load_ext = req_unsigned ? {56'd0, rd_shift[7:0]}
                                       : {{56{rd_shift[7]}}, rd_shift[7:0]};
      2'd1:    load_ext = req_unsigned ? {48'd0, rd_shift[15:0]}
                                       : {{48{rd_shift[15]}}, rd_shift[15:0]};
      2'd2:    load_ext = req_unsigned ? {32'd0, rd_shift[31:0]}
                                       : {{32{rd_shift[31]}}, rd_shift[31:0]};
      default: load_ext = rd_shift;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_rdata_d = '0;
    idx_d        = idx_q;
    merged_d     = merged_q;
    req_ready    = 1'b0;
    dm_memread   = 1'b0;
    dm_memwrite  = 1'b0;
    dm_addr      = '0;
    dm_wdata     = '0;

    // Everything the DM or upstream sees is held low while reset is asserted.
    if (!rst) begin
      case (state_q)
        IDLE: begin
          req_ready  = 1'b1;
          dm_addr    = {3'b000, idx};
          dm_memread = req_valid && req_ok;
          if (req_valid) begin
            if (!req_ok) begin
              resp_valid_d = 1'b1;
              resp_err_d   = 1'b1;
            end else if (!req_we) begin
              resp_valid_d = 1'b1;
              resp_rdata_d = load_ext;
            end else if (req_size == 2'd3) begin
              dm_memwrite  = 1'b1;
              dm_wdata     = req_wdata;
              resp_valid_d = 1'b1;
            end else begin
              merged_d = merged;
              idx_d    = idx[IDX_W-1:0];
              state_d  = RMW_WR;
            end
          end
        end
        RMW_WR: begin
          dm_memwrite  = 1'b1;
          dm_addr      = 64'(idx_q);
          dm_wdata     = merged_q;
          resp_valid_d = 1'b1;
          state_d      = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      idx_q        <= '0;
      merged_q     <= '0;
    end else begin
      state_q      <= state_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
      idx_q        <= idx_d;
      merged_q     <= merged_d;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_lsu_align.sv
// Bench for lsu_align: directed scenarios with literal expectations, then random traffic,
// all checked every cycle against a byte-level memory/response model.
module tb_lsu_align;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic        req_unsigned = 1'b0;
  logic [63:0] req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic        resp_err;
  logic [63:0] dm_addr, dm_wdata, dm_rdata;
  logic        dm_memwrite, dm_memread;

  lsu_align #(.DEPTH(64), .IDX_W(6)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_memwrite(dm_memwrite), .dm_memread(dm_memread), .dm_rdata(dm_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %h, expected %h", nm, cyc, act, exp);
    end
  endtask

  function automatic logic [63:0] init_word(input int i);
    if (i == 2) return 64'h8877665544332211;
    return {32'(i) * 32'h9E3779B9, ~(32'(i) * 32'h85EBCA6B)};
  endfunction

  // Data memory: combinational read, write on the clock edge; contents survive reset.
  logic [63:0] dm_mem [0:63];
  assign dm_rdata = (dm_addr < 64'd64) ? dm_mem[dm_addr[5:0]] : 64'h0;
  initial begin
    for (int i = 0; i < 64; i++) dm_mem[i] <= init_word(i);
    forever begin
      @(posedge clk);
      if (dm_memwrite && dm_addr < 64'd64) dm_mem[dm_addr[5:0]] <= dm_wdata;
    end
  end

  function automatic logic [63:0] model_load(input logic [63:0] w, input int off, input int sz,
                                             input bit uns);
    int nb;
    logic [63:0] v;
    nb = 1 << sz;
    v  = '0;
    for (int b = 0; b < nb; b++) v[8*b +: 8] = w[8*(off+b) +: 8];
    if (!uns && nb < 8 && v[8*nb-1]) begin
      for (int b = nb; b < 8; b++) v[8*b +: 8] = 8'hFF;
    end
    return v;
  endfunction

  function automatic logic [63:0] model_store(input logic [63:0] w, input int off, input int sz,
                                              input logic [63:0] wd);
    logic [63:0] v;
    v = w;
    for (int b = 0; b < (1 << sz); b++) v[8*(off+b) +: 8] = wd[8*b +: 8];
    return v;
  endfunction

  typedef struct {
    int          due;
    int          acc;
    logic        err;
    logic [63:0] rdata;
    bit          commit;
    int          idx;
    logic [63:0] cdata;
  } exp_t;

  typedef struct {
    int          cyc;
    int          acc;
    logic [63:0] rdata;
    logic        err;
  } log_t;

  logic [63:0] ref_mem [0:63];
  exp_t        exp_q [$];
  log_t        rlog [$];

  // Reference model and single compare process, evaluated on the falling edge.
  initial begin
    exp_t        e;
    log_t        l;
    bit          rmw_v, busy, err;
    int          rmw_cyc, rmw_idx, sz, off;
    logic [63:0] rmw_data, widx;
    rmw_v = 0; rmw_cyc = 0; rmw_idx = 0; rmw_data = '0;
    for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_err", resp_err, 0);
        chk("rst_resp_rdata", resp_rdata, 0);
        chk("rst_memwrite", dm_memwrite, 0);
        chk("rst_memread", dm_memread, 0);
        chk("rst_req_ready", req_ready, 0);
        exp_q.delete();
        rmw_v = 0;
      end else begin
        busy = rmw_v && (cyc == rmw_cyc + 1);
        if (exp_q.size() != 0 && exp_q[0].due == cyc) begin
          e = exp_q.pop_front();
          chk("resp_valid", resp_valid, 1);
          chk("resp_err", resp_err, e.err);
          chk("resp_rdata", resp_rdata, e.rdata);
          if (e.commit) ref_mem[e.idx] = e.cdata;
          l.cyc = cyc; l.acc = e.acc; l.rdata = resp_rdata; l.err = resp_err;
          rlog.push_back(l);
        end else begin
          chk("resp_valid_quiet", resp_valid, 0);
        end
        chk("req_ready", req_ready, !busy);
        if (busy) begin
          chk("rmw_memwrite", dm_memwrite, 1);
          chk("rmw_memread", dm_memread, 0);
          chk("rmw_addr", dm_addr, 64'(rmw_idx));
          chk("rmw_wdata", dm_wdata, rmw_data);
          rmw_v = 0;
        end else if (req_valid) begin
          sz   = int'(req_size);
          off  = int'(req_addr[2:0]);
          widx = req_addr >> 3;
          err  = (off % (1 << sz)) != 0 || widx >= 64;
          chk("memread", dm_memread, !err);
          chk("memwrite", dm_memwrite, !err && req_we && sz == 3);
          if (!err) chk("dm_addr", dm_addr, widx);
          e.acc = cyc; e.due = cyc + 1; e.err = err; e.rdata = '0;
          e.commit = 0; e.idx = int'(widx[5:0]); e.cdata = '0;
          if (!err && !req_we) begin
            e.rdata = model_load(ref_mem[e.idx], off, sz, req_unsigned);
          end else if (!err && sz == 3) begin
            chk("dbl_wdata", dm_wdata, req_wdata);
            ref_mem[e.idx] = req_wdata;
          end else if (!err) begin
            e.cdata = model_store(ref_mem[e.idx], off, sz, req_wdata);
            e.commit = 1; e.due = cyc + 2;
            rmw_v = 1; rmw_cyc = cyc; rmw_idx = e.idx; rmw_data = e.cdata;
          end
          exp_q.push_back(e);
        end else begin
          chk("quiet_memread", dm_memread, 0);
          chk("quiet_memwrite", dm_memwrite, 0);
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Presents a request and holds it until accepted; returns 1 ns after the accepting edge.
  task automatic issue(input bit we, input bit [1:0] sz, input bit uns, input logic [63:0] a,
                       input logic [63:0] wd);
    bit done;
    done = 0;
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = a; req_wdata = wd;
    for (int t = 0; t < 20 && !done; t++) begin
      @(negedge clk);
      done = req_ready;
      @(posedge clk);
      #1;
    end
    if (!done) chk("accept_timeout", 0, 1);
    req_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int          b;
    logic [63:0] saved;
    int          idx, off, sz;
    logic [63:0] a;

    idle(3);
    rst = 1'b0;
    idle(1);

    // Byte loads, signed then unsigned, from the top lane of DM[2].
    b = rlog.size();
    issue(0, 2'd0, 0, 64'h17, '0);
    issue(0, 2'd0, 1, 64'h17, '0);
    idle(3);
    chk("t1_count", 64'(rlog.size() - b), 2);
    chk("t1_signed", rlog[b].rdata, 64'hFFFFFFFFFFFFFF88);
    chk("t1_unsigned", rlog[b+1].rdata, 64'h0000000000000088);
    chk("t1_lat0", 64'(rlog[b].cyc - rlog[b].acc), 1);
    chk("t1_lat1", 64'(rlog[b+1].cyc - rlog[b+1].acc), 1);

    // Half store; high garbage in wdata must be ignored.
    b = rlog.size();
    issue(1, 2'd1, 0, 64'h12, 64'hDEAD00000000BEEF);
    idle(3);
    chk("t2_mem", dm_mem[2], 64'h88776655BEEF2211);
    chk("t2_lat", 64'(rlog[b].cyc - rlog[b].acc), 2);
    chk("t2_rdata", rlog[b].rdata, 0);

    // Misaligned word load and out-of-range double load.
    b = rlog.size();
    issue(0, 2'd2, 0, 64'h16, '0);
    issue(0, 2'd3, 0, 64'h200, '0);
    idle(3);
    chk("t3_err0", rlog[b].err, 1);
    chk("t3_rd0", rlog[b].rdata, 0);
    chk("t3_err1", rlog[b+1].err, 1);
    chk("t3_rd1", rlog[b+1].rdata, 0);

    // Double store then immediate load of the same address.
    b = rlog.size();
    issue(1, 2'd3, 0, 64'h08, 64'h0123456789ABCDEF);
    issue(0, 2'd3, 1, 64'h08, '0);
    idle(3);
    chk("t4_mem", dm_mem[1], 64'h0123456789ABCDEF);
    chk("t4_load", rlog[b+1].rdata, 64'h0123456789ABCDEF);
    chk("t4_lat", 64'(rlog[b].cyc - rlog[b].acc), 1);

    // Reset during the RMW write cycle: no write, no response.
    saved = dm_mem[4];
    b = rlog.size();
    issue(1, 2'd0, 0, 64'h21, 64'h5A);
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    #1;
    chk("t5_ready", req_ready, 1);
    idle(3);
    chk("t5_mem", dm_mem[4], saved);
    chk("t5_noresp", 64'(rlog.size() - b), 0);

    // Word store with a load queued right behind it.
    b = rlog.size();
    issue(1, 2'd2, 0, 64'h0C, 64'h11111111CAFEF00D);
    issue(0, 2'd2, 0, 64'h0C, '0);
    idle(4);
    chk("t6_count", 64'(rlog.size() - b), 2);
    chk("t6_store_rd", rlog[b].rdata, 0);
    chk("t6_load", rlog[b+1].rdata, 64'hFFFFFFFFCAFEF00D);
    chk("t6_acc_gap", 64'(rlog[b+1].acc - rlog[b].acc), 2);
    chk("t6_order", 64'(rlog[b+1].cyc - rlog[b].cyc), 1);

    // Random traffic with occasional errors, gaps and resets.
    for (int n = 0; n < 400; n++) begin
      sz  = $urandom_range(0, 3);
      idx = ($urandom_range(0, 15) == 0) ? 64 + $urandom_range(0, 3) : $urandom_range(0, 63);
      if ($urandom_range(0, 7) == 0) off = $urandom_range(0, 7);
      else off = ($urandom_range(0, 7) >> sz) << sz;
      a = (64'(idx) << 3) | 64'(off);
      if ($urandom_range(0, 31) == 0) a[63] = 1'b1;
      issue(1'($urandom_range(0, 1)), 2'(sz), 1'($urandom_range(0, 1)), a,
            {$urandom, $urandom});
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      if ($urandom_range(0, 59) == 0) begin
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
      end
    end
    idle(4);
    for (int i = 0; i < 64; i++) chk($sformatf("final_mem[%0d]", i), dm_mem[i], ref_mem[i]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
